ov7670_stream_gen: RTL and testbench
====================================

OV7670_STREAM_GEN -- requirements
Module: ov7670_stream_gen

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line.
REQ-002 The module SHALL have parameter H_BLANK, default 144, meaning blank pixel-times per line.
REQ-003 The module SHALL have parameters V_SYNC, V_BP, V_ACTIVE and V_FP, defaults 3/17/480/10, each a line count.
REQ-004 The module SHALL have port clk_50, input, 1 bit, the single system clock.
REQ-005 The module SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The module SHALL have port enable, input, 1 bit, which requests continuous frame generation.
REQ-007 The module SHALL have port pclk, output, 1 bit, the pixel clock to the camera receiver.
REQ-008 The module SHALL have ports vsync and href, outputs, 1 bit each, active-high frame and line valid.
REQ-009 The module SHALL have port data, output, 8 bits, the YCbCr 4:2:2 byte stream.
REQ-010 The module SHALL have ports mem_addr (output, 19 bits), mem_rd (output, 1 bit) and mem_data (input, 8 bits), forming the frame-buffer read port.
REQ-011 The module SHALL have ports frame_done (output, 1 bit, one-cycle pulse) and busy (output, 1 bit, frame in progress).

Function
REQ-012 pclk SHALL toggle every clk_50 cycle while busy=1 (25 MHz) and SHALL be held at 0 in IDLE.
REQ-013 vsync, href and data SHALL change only on the clk_50 edge where pclk goes 1->0, so they are stable at every pclk rise.
REQ-014 The state machine SHALL be IDLE->VSYNC->VBP->ACTIVE->VFP, dwelling V_SYNC, V_BP, V_ACTIVE and V_FP lines respectively.
REQ-015 From VFP it SHALL go to VSYNC if enable=1, else to IDLE; IDLE->VSYNC SHALL occur when enable=1 is sampled.
REQ-016 Every line SHALL last 2*(H_ACTIVE+H_BLANK) pclk periods.
REQ-017 vsync SHALL be 1 only in VSYNC; href SHALL be 1 only in ACTIVE, for the first 2*H_ACTIVE periods of each line.
REQ-018 Within href, even byte index SHALL be chroma 8'h80 and odd byte index SHALL be Y = mem_data for that pixel; data SHALL be 0 whenever href=0.
REQ-019 mem_rd SHALL pulse for exactly one clk_50 cycle during each chroma byte period.
REQ-020 mem_data SHALL be captured exactly one clk_50 cycle after mem_rd and output as the following Y byte.
REQ-021 mem_addr SHALL equal y*H_ACTIVE+x at each read, SHALL clear to 0 on VSYNC entry, and SHALL reach H_ACTIVE*V_ACTIVE-1 on the last read.
REQ-022 frame_done SHALL pulse for one clk_50 cycle at the final clk_50 cycle of VFP; busy SHALL be 1 in all states except IDLE.
REQ-023 Deasserting enable mid-frame SHALL NOT abort the frame; the frame completes and the FSM goes to IDLE.
REQ-024 Counters SHALL be sized by $clog2 of their parameter ranges, and all arithmetic SHALL be unsigned without overflow at default parameters.

Reset
REQ-025 reset_n=0 SHALL immediately force state IDLE and all counters to 0.
REQ-026 During reset, all outputs SHALL be 0: pclk, vsync, href, data, mem_addr, mem_rd, frame_done and busy.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no frame_done.
REQ-028 After reset release, the next frame SHALL start with a full VSYNC.

Structure
REQ-029 Package ov7670_pkg SHALL hold the FSM state enum, default timing constants and CHROMA_NEUTRAL=8'h80.
REQ-030 A sub-module ov7670_line_timer SHALL own the pclk phase, byte and line counters, and SHALL emit end-of-line and end-of-phase strobes to the FSM.

Verification (H_ACTIVE=4, H_BLANK=2, V_SYNC=1, V_BP=1, V_ACTIVE=2, V_FP=1)
REQ-031 Bench: pulse enable for one cycle -> vsync high for exactly 12 pclk periods, then 12 periods of VBP, then href high for 8 periods per active line.
REQ-032 Bench: memory returns data equal to address -> bytes 80,00,80,01,80,02,80,03 on line 0, then 80,04..80,07 on line 1.
REQ-033 Bench: mem_rd pulse count per frame = 8; last mem_addr = 7; one frame_done per 60 pclk periods (120 clk_50 cycles).
REQ-034 Bench: drop enable during ACTIVE -> the frame finishes, frame_done fires once, then busy=0 and pclk stays 0.
REQ-035 Bench: assert reset_n=0 mid-line -> all outputs are 0 in the same cycle; after release the next frame starts with vsync.
REQ-036 Bench: assertion that vsync, href and data never change on a clk_50 edge where pclk rises.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and default timing for the OV7670-style camera stream generator.
package ov7670_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } state_t;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_BLANK_DEF  = 144;
    localparam int unsigned V_SYNC_DEF   = 3;
    localparam int unsigned V_BP_DEF     = 17;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned ADDR_W       = 19;
    localparam int unsigned DATA_W       = 8;

    localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ov7670_line_timer.sv
// Pixel-clock phase, byte-in-line and line-in-phase counters with edge/end strobes.
module ov7670_line_timer #(
    parameter int unsigned LINE_BYTES = 1568,
    parameter int unsigned BYTE_W     = 11,
    parameter int unsigned LINE_W     = 9
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              run,
    input  logic [LINE_W-1:0] line_last,
    output logic              pclk,
    output logic [BYTE_W-1:0] byte_cnt,
    output logic [LINE_W-1:0] line_cnt,
    output logic              rise_c,
    output logic              fall_c,
    output logic              eol_c,
    output logic              eop_c
);

    // A byte period ends on the edge where pclk drops from 1 to 0.
    assign rise_c = run && !pclk;
    assign fall_c = run && pclk;
    assign eol_c  = fall_c && (byte_cnt == BYTE_W'(LINE_BYTES - 1));
    assign eop_c  = eol_c && (line_cnt == line_last);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            pclk     <= 1'b0;
            byte_cnt <= '0;
            line_cnt <= '0;
        end else if (!run) begin
            pclk     <= 1'b0;
            byte_cnt <= '0;
            line_cnt <= '0;
        end else begin
            pclk <= ~pclk;
            if (fall_c) begin
                byte_cnt <= eol_c ? '0 : byte_cnt + BYTE_W'(1);
            end
            if (eol_c) begin
                line_cnt <= eop_c ? '0 : line_cnt + LINE_W'(1);
            end
        end
    end

endmodule

// File: rtl/ov7670_stream_gen.sv
// Generates an OV7670-style YCbCr 4:2:2 stream (pclk/vsync/href/data) from a frame buffer.
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_BLANK  = H_BLANK_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              enable,
    output logic              pclk,
    output logic              vsync,
    output logic              href,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned LINE_BYTES = 2 * (H_ACTIVE + H_BLANK);
    localparam int unsigned HREF_BYTES = 2 * H_ACTIVE;
    localparam int unsigned BYTE_W     = cnt_w(LINE_BYTES);
    localparam int unsigned LINE_W     = cnt_w(max4(V_SYNC, V_BP, V_ACTIVE, V_FP));

    state_t              state_q;
    state_t              state_d;
    logic [LINE_W-1:0]   line_last;
    logic [BYTE_W-1:0]   byte_cnt;
    logic [LINE_W-1:0]   line_cnt;
    logic                rise_c;
    logic                fall_c;
    logic                eol_c;
    logic                eop_c;
    logic                run;

    logic                vsync_d;
    logic                href_d;
    logic [DATA_W-1:0]   data_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                mem_rd_d;
    logic                frame_done_d;
    logic                busy_d;
    logic                upd;
    logic [BYTE_W-1:0]   nxt_byte;
    logic [LINE_W-1:0]   nxt_line;

    assign run = (state_q != ST_IDLE);

    ov7670_line_timer #(
        .LINE_BYTES (LINE_BYTES),
        .BYTE_W     (BYTE_W),
        .LINE_W     (LINE_W)
    ) u_line_timer (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .run       (run),
        .line_last (line_last),
        .pclk      (pclk),
        .byte_cnt  (byte_cnt),
        .line_cnt  (line_cnt),
        .rise_c    (rise_c),
        .fall_c    (fall_c),
        .eol_c     (eol_c),
        .eop_c     (eop_c)
    );

    // Index of the last line in the current phase; kept apart from the FSM to avoid a false loop.
    always_comb begin
        line_last = '0;
        case (state_q)
            ST_VSYNC:  line_last = LINE_W'(V_SYNC - 1);
            ST_VBP:    line_last = LINE_W'(V_BP - 1);
            ST_ACTIVE: line_last = LINE_W'(V_ACTIVE - 1);
            ST_VFP:    line_last = LINE_W'(V_FP - 1);
            default:   line_last = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        vsync_d      = vsync;
        href_d       = href;
        data_d       = data;
        mem_addr_d   = mem_addr;
        mem_rd_d     = 1'b0;
        frame_done_d = 1'b0;
        upd          = 1'b0;
        nxt_byte     = '0;
        nxt_line     = '0;

        case (state_q)
            ST_IDLE:   if (enable) state_d = ST_VSYNC;
            ST_VSYNC:  if (eop_c)  state_d = ST_VBP;
            ST_VBP:    if (eop_c)  state_d = ST_ACTIVE;
            ST_ACTIVE: if (eop_c)  state_d = ST_VFP;
            ST_VFP:    if (eop_c)  state_d = enable ? ST_VSYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);

        // Stream outputs move only where pclk falls (or at frame start, with pclk held low).
        upd = fall_c || ((state_q == ST_IDLE) && enable);
        if (fall_c && !eol_c) begin
            nxt_byte = byte_cnt + BYTE_W'(1);
        end
        if (fall_c && !eop_c) begin
            nxt_line = eol_c ? line_cnt + LINE_W'(1) : line_cnt;
        end

        if (upd) begin
            vsync_d  = (state_d == ST_VSYNC);
            href_d   = (state_d == ST_ACTIVE) && (32'(nxt_byte) < HREF_BYTES);
            mem_rd_d = href_d && !nxt_byte[0];
            if (!href_d) begin
                data_d = '0;
            end else if (!nxt_byte[0]) begin
                data_d = CHROMA_NEUTRAL;
            end else begin
                data_d = mem_data;
            end
            if (mem_rd_d) begin
                mem_addr_d = ADDR_W'(nxt_line) * ADDR_W'(H_ACTIVE) + ADDR_W'(nxt_byte >> 1);
            end
        end

        if ((state_d == ST_VSYNC) && (state_q != ST_VSYNC)) begin
            mem_addr_d = '0;
        end

        // Registered so the pulse lands on the last clk_50 cycle of the front porch.
        frame_done_d = (state_q == ST_VFP) && rise_c &&
                       (byte_cnt == BYTE_W'(LINE_BYTES - 1)) && (line_cnt == line_last);
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            vsync      <= 1'b0;
            href       <= 1'b0;
            data       <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            vsync      <= vsync_d;
            href       <= href_d;
            data       <= data_d;
            mem_addr   <= mem_addr_d;
            mem_rd     <= mem_rd_d;
            frame_done <= frame_done_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed/randomized bench for ov7670_stream_gen at reduced frame timing.
module tb_ov7670_stream_gen;

    localparam int HA  = 4;
    localparam int HB  = 2;
    localparam int VS  = 1;
    localparam int VB  = 1;
    localparam int VA  = 2;
    localparam int VF  = 1;
    localparam int LB  = 2 * (HA + HB);
    localparam int FRAME_CYC = 2 * LB * (VS + VB + VA + VF);

    logic        clk_50 = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        pclk;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic [18:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic        frame_done;
    logic        busy;

    logic [7:0]  mem [8];

    int n_cmp = 0;
    int n_bad = 0;

    logic       p_pclk  = 1'b0;
    logic       p_vsync = 1'b0;
    logic       p_href  = 1'b0;
    logic [7:0] p_data  = 8'h00;

    ov7670_stream_gen #(
        .H_ACTIVE (HA),
        .H_BLANK  (HB),
        .V_SYNC   (VS),
        .V_BP     (VB),
        .V_ACTIVE (VA),
        .V_FP     (VF)
    ) dut (
        .clk_50     (clk_50),
        .reset_n    (reset_n),
        .enable     (enable),
        .pclk       (pclk),
        .vsync      (vsync),
        .href       (href),
        .data       (data),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #10 clk_50 = ~clk_50;

    // Synchronous-read frame buffer: data valid the cycle after mem_rd.
    always @(posedge clk_50) begin
        if (mem_rd) mem_data <= mem[mem_addr[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50);
        #1;
        if (!p_pclk && pclk) begin
            check("stable_at_pclk_rise", {22'd0, vsync, href, data}, {22'd0, p_vsync, p_href, p_data});
        end
        p_pclk  = pclk;
        p_vsync = vsync;
        p_href  = href;
        p_data  = data;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {26'd0, pclk, vsync, href, mem_rd, frame_done, busy}, 32'd0);
        check({tag, "_bus"}, {5'd0, mem_addr, data}, 32'd0);
    endtask

    task automatic check_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check("idle_ctl", {28'd0, pclk, vsync, href, busy}, 32'd0);
            step();
        end
    endtask

    // Walk one frame from its first cycle, comparing against timing computed from line/phase arithmetic.
    task automatic run_frame(input int drop_c, input bit rand_mem);
        int          rd_cnt;
        logic [18:0] last_a;
        int k, ln, b, ph, rd_idx;
        logic exp_vs, exp_hr, exp_rd;
        logic [7:0] exp_d;
        rd_cnt = 0;
        last_a = '1;
        for (int i = 0; i < 8; i++) mem[i] = rand_mem ? 8'($urandom) : 8'(i);
        for (int c = 0; c < FRAME_CYC; c++) begin
            k  = c / 2;
            ln = k / LB;
            b  = k % LB;
            ph = (ln < VS) ? 0 : (ln < VS + VB) ? 1 : (ln < VS + VB + VA) ? 2 : 3;
            rd_idx = (ln - VS - VB) * HA + b / 2;
            exp_vs = (ph == 0);
            exp_hr = (ph == 2) && (b < 2 * HA);
            exp_rd = exp_hr && (b % 2 == 0) && (c % 2 == 0);
            exp_d  = !exp_hr ? 8'h00 : (b % 2 == 0) ? 8'h80 : mem[rd_idx];
            check("pclk", {31'd0, pclk}, {31'd0, 1'(c % 2)});
            check("busy", {31'd0, busy}, 32'd1);
            check("frame_done", {31'd0, frame_done}, {31'd0, c == FRAME_CYC - 1});
            check("mem_rd", {31'd0, mem_rd}, {31'd0, exp_rd});
            if (mem_rd) begin
                check("mem_addr", {13'd0, mem_addr}, 32'(rd_idx));
                rd_cnt++;
                last_a = mem_addr;
            end
            if (c % 2 == 1) begin
                check("vsync", {31'd0, vsync}, {31'd0, exp_vs});
                check("href", {31'd0, href}, {31'd0, exp_hr});
                check("data", {24'd0, data}, {24'd0, exp_d});
            end
            if (c == drop_c) enable = 1'b0;
            step();
        end
        check("rd_count", 32'(rd_cnt), 32'(HA * VA));
        check("last_addr", {13'd0, last_a}, 32'(HA * VA - 1));
    endtask

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        mem_data = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = 8'(i);
        repeat (3) step();
        check_all_zero("reset");
        reset_n = 1'b1;
        check_idle(4);

        // Single enable pulse, memory returns its own address.
        enable = 1'b1;
        step();
        enable = 1'b0;
        run_frame(-1, 1'b0);
        check_idle(6);

        // Back-to-back frames, enable dropped mid-ACTIVE of the third.
        enable = 1'b1;
        step();
        run_frame(-1, 1'b1);
        run_frame(-1, 1'b1);
        run_frame(60, 1'b1);
        check_idle(8);

        // Reset in the middle of an active line.
        enable = 1'b1;
        step();
        for (int i = 0; i < 53; i++) step();
        reset_n = 1'b0;
        #1;
        check_all_zero("reset_midline");
        step();
        step();
        check_all_zero("reset_hold");
        reset_n = 1'b1;
        step();
        check("restart_vsync", {31'd0, vsync}, 32'd1);
        run_frame(10, 1'b1);
        check_idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
